// File: rtl/dct_mac_pkg.sv
// Shared definitions for the DCT multiply-accumulate units.
// Holds the round/overflow mode constants and the width helpers. Every dct_unit
// instance uses these helpers to size its product and accumulator paths.
package dct_mac_pkg;

  // Rounding mode applied when the coefficient fraction bits are removed.
  localparam int unsigned ROUND_TRUNC   = 0;  // arithmetic shift (floor)
  localparam int unsigned ROUND_HALF_UP = 1;  // round half toward +inf

  // Handling of results outside the signed output range.
  localparam int unsigned OVF_WRAP = 0;  // keep the low OUT_W bits
  localparam int unsigned OVF_SAT  = 1;  // clamp to the signed limits

  // Full-precision signed product width.
  function automatic int unsigned prod_width(input int unsigned data_w,
                                             input int unsigned coef_w);
    return data_w + coef_w;
  endfunction

  // Accumulator width: one product plus headroom for summing taps products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return prod_width(data_w, coef_w) + $clog2(taps);
  endfunction

  // Working width inside round/saturate. It must hold the rounding carry out
  // of the accumulator and also both OUT_W signed limits.
  function automatic int unsigned rs_width(input int unsigned acc_w,
                                           input int unsigned out_w);
    return ((acc_w > out_w) ? acc_w : out_w) + 2;
  endfunction

endpackage

// File: rtl/dct_mac_round_sat.sv
// Round / saturate stage of the DCT MAC (purely combinational).
// Ports:
//   sum - accumulated dot product, ACC_W bits, signed, FRAC_BITS fraction bits
//   res - rounded result, OUT_W bits, signed (clamped or wrapped per SAT)
//   ovf - the shifted value lies outside the OUT_W signed range
module dct_mac_round_sat
  import dct_mac_pkg::*;
#(
  parameter int unsigned ACC_W     = 27,
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned FRAC_BITS = 11,
  parameter int unsigned ROUND     = ROUND_HALF_UP,
  parameter int unsigned SAT       = OVF_SAT
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] res,
  output logic                    ovf
);

  localparam int unsigned EXT_W = rs_width(ACC_W, OUT_W);

  localparam logic signed [EXT_W-1:0] MaxOut = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MinOut = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] Half   = {{(EXT_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [EXT_W-1:0] RoundAdd = (ROUND == ROUND_HALF_UP) ? Half : '0;

  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    sum_ext = {{(EXT_W-ACC_W){sum[ACC_W-1]}}, sum};
    rounded = sum_ext + RoundAdd;
    shifted = rounded >>> FRAC_BITS;
    ovf     = (shifted > MaxOut) || (shifted < MinOut);
    if ((SAT == OVF_SAT) && ovf) begin
      res = shifted[EXT_W-1] ? MinOut[OUT_W-1:0] : MaxOut[OUT_W-1:0];
    end else begin
      res = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dct_mac_pipe.sv
// Pipelined multiply-accumulate for the forward-DCT datapath.
// It takes one sample/coefficient pair per cycle and accumulates TAPS products
// into one dot product. The result is rounded and saturated, then held in an
// output register behind a valid/ready handshake with full back-pressure.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ena                 - global clock enable (output handshake ignores it)
//   clr                 - synchronous abort of partial accumulation / in-flight taps
//   in_valid/in_ready   - tap handshake; in_data/in_coef signed operands
//   out_valid/out_ready - result handshake; out_data signed result, out_ovf overflow
module dct_mac_pipe
  import dct_mac_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned COEF_W    = 12,
  parameter int unsigned TAPS      = 8,
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned FRAC_BITS = 11,
  parameter int unsigned ROUND     = ROUND_HALF_UP,
  parameter int unsigned SAT       = OVF_SAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam int unsigned PROD_W = prod_width(DATA_W, COEF_W);
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam logic [TAP_W-1:0] LastTap = TAP_W'(TAPS - 1);

  // Low while in reset and for the first edge after release, so in_ready
  // reads 0 under reset without a combinational path from rst_n.
  logic run_q;

  logic [TAP_W-1:0]         tap_idx_q, tap_idx_d;
  // Stage 1: captured operands
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
  logic signed [COEF_W-1:0] s1_coef_q, s1_coef_d;
  // Stage 2: full-precision product
  logic                     s2_valid_q, s2_valid_d;
  logic                     s2_last_q, s2_last_d;
  logic signed [PROD_W-1:0] mult_res_q, mult_res_d;
  // Stage 3: accumulator and output register
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;

  logic                     advance;
  logic                     flush;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [OUT_W-1:0]  rs_res;
  logic                     rs_ovf;

  assign advance = run_q & ena & (~out_valid_q | out_ready) & ~clr;
  assign flush   = ena & clr;

  assign prod = s1_data_q * s1_coef_q;
  assign sum  = acc_q + {{(ACC_W-PROD_W){mult_res_q[PROD_W-1]}}, mult_res_q};

  dct_mac_round_sat #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .FRAC_BITS(FRAC_BITS),
    .ROUND    (ROUND),
    .SAT      (SAT)
  ) u_round_sat (
    .sum(sum),
    .res(rs_res),
    .ovf(rs_ovf)
  );

  always_comb begin
    tap_idx_d   = tap_idx_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_data_d   = s1_data_q;
    s1_coef_d   = s1_coef_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    mult_res_d  = mult_res_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    // Consumption of the held result; a new final result below overrides it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      // A result already in the output register is kept.
      tap_idx_d  = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      acc_d      = '0;
    end else if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_coef_d = in_coef;
        s1_last_d = (tap_idx_q == LastTap);
        tap_idx_d = (tap_idx_q == LastTap) ? '0 : tap_idx_q + 1'b1;
      end

      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      if (s1_valid_q) begin
        mult_res_d = prod;
      end

      if (s2_valid_q) begin
        if (s2_last_q) begin
          acc_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = rs_res;
          out_ovf_d   = rs_ovf;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      tap_idx_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_coef_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      mult_res_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      tap_idx_q   <= tap_idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_data_q   <= s1_data_d;
      s1_coef_q   <= s1_coef_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      mult_res_q  <= mult_res_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Self-checking bench for dct_mac_pipe. Three instances share the same stimulus:
// the default (round, saturate), ROUND=0 and SAT=0. A dot-product model predicts
// each finished block; a negedge monitor compares every delivered result in order.
module tb_dct_mac_pipe;

  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [11:0] in_data = '0;
  logic signed [11:0] in_coef = '0;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic signed [11:0] out_data0, out_data1, out_data2;
  logic out_ovf0, out_ovf1, out_ovf2;

  always #5 clk = ~clk;

  dct_mac_pipe u_dut_rs (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_coef(in_coef),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0)
  );

  dct_mac_pipe #(.ROUND(0)) u_dut_trunc (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_coef(in_coef),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ovf(out_ovf1)
  );

  dct_mac_pipe #(.SAT(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_coef(in_coef),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ovf(out_ovf2)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit ena_toggle = 1'b0;
  bit rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint acc_m = 0;
  int cnt_m = 0;
  logic [12:0] exp0[$];
  logic [12:0] exp1[$];
  logic [12:0] exp2[$];

  // {ovf, data} for a dot product with 11 fraction bits and a 12-bit result.
  function automatic logic [12:0] ref_result(input longint s, input bit rnd, input bit sat);
    longint v;
    longint q;
    logic [12:0] r;
    v = s + (rnd ? longint'(1024) : longint'(0));
    q = v / 2048;
    if ((v % 2048) != 0 && v < 0) q = q - 1;  // floor division
    r[12] = (q > 2047) || (q < -2048);
    if (sat && q > 2047) r[11:0] = 12'h7ff;
    else if (sat && q < -2048) r[11:0] = 12'h800;
    else r[11:0] = q[11:0];
    return r;
  endfunction

  task automatic model_accept(input logic signed [11:0] d, input logic signed [11:0] c);
    acc_m += longint'(d) * longint'(c);
    cnt_m++;
    if (cnt_m == TAPS) begin
      exp0.push_back(ref_result(acc_m, 1'b1, 1'b1));
      exp1.push_back(ref_result(acc_m, 1'b0, 1'b1));
      exp2.push_back(ref_result(acc_m, 1'b1, 1'b0));
      acc_m = 0;
      cnt_m = 0;
    end
  endtask

  task automatic model_clear();
    acc_m = 0;
    cnt_m = 0;
  endtask

  // ---------------- output monitor ----------------
  task automatic pop_check(input int k, input logic signed [11:0] d, input logic f);
    logic [12:0] e;
    int qs;
    e = '0;
    case (k)
      0: qs = exp0.size();
      1: qs = exp1.size();
      default: qs = exp2.size();
    endcase
    check_eq($sformatf("result_expected_dut%0d", k), qs != 0, 1);
    if (qs != 0) begin
      case (k)
        0: e = exp0.pop_front();
        1: e = exp1.pop_front();
        default: e = exp2.pop_front();
      endcase
      check_eq($sformatf("out_data_dut%0d", k), d, $signed(e[11:0]));
      check_eq($sformatf("out_ovf_dut%0d", k), f, e[12]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (out_valid0) pop_check(0, out_data0, out_ovf0);
      if (out_valid1) pop_check(1, out_data1, out_ovf1);
      if (out_valid2) pop_check(2, out_data2, out_ovf2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (ena_toggle) ena = ~ena;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_tap(input logic signed [11:0] d, input logic signed [11:0] c);
    int waited = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_coef = c;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (!ena) check_eq("ena_low_in_ready", in_ready0, 0);
      if (in_ready0) ok = 1'b1;
      else begin
        waited++;
        step();
      end
    end
    if (!ok) begin
      check_eq("tap_accept_timeout", waited, 0);
      in_valid = 1'b0;
    end else begin
      model_accept(d, c);
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_taps(input logic signed [11:0] d, input logic signed [11:0] c,
                            input int n);
    for (int i = 0; i < n; i++) drive_tap(d, c);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp0.size() != 0 || out_valid0) && w < 200) begin
      step();
      w++;
    end
    check_eq("drain_pending", exp0.size(), 0);
  endtask

  task automatic wait_out_valid(input string tag);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid0 && w < 50);
    check_eq(tag, out_valid0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    int en_edges;
    logic signed [11:0] rd;
    logic signed [11:0] rc;

    // Reset values
    #12;
    check_eq("rst_out_valid", out_valid0, 0);
    check_eq("rst_out_data", out_data0, 0);
    check_eq("rst_out_ovf", out_ovf0, 0);
    check_eq("rst_in_ready", in_ready0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Basic dot product, throughput and latency
    c0 = cyc;
    drive_taps(100, 1024, 8);
    check_eq("basic_throughput", cyc - c0, 8);
    @(negedge clk);
    check_eq("latency_edge1", out_valid0, 0);
    step();
    @(negedge clk);
    check_eq("latency_edge2", out_valid0, 0);
    step();
    @(negedge clk);
    check_eq("latency_edge3", out_valid0, 1);
    check_eq("basic_data", out_data0, 400);
    check_eq("basic_ovf", out_ovf0, 0);
    wait_drain();

    // Rounding: a single nonzero tap per block
    drive_tap(3, 1024);
    drive_taps(0, 1024, 7);
    drive_tap(-3, 1024);
    drive_taps(0, 1024, 7);
    wait_drain();

    // Saturation / wrap, back to back with no bubble
    drive_taps(2047, 2047, 8);
    drive_taps(-2048, 2047, 8);
    wait_drain();

    // Back-pressure across two blocks
    out_ready = 1'b0;
    fork
      begin
        drive_taps(100, 1024, 8);
        drive_taps(-100, 1024, 8);
      end
      begin
        wait_out_valid("bp_first_pending");
        repeat (4) begin
          @(negedge clk);
          check_eq("bp_in_ready_low", in_ready0, 0);
          check_eq("bp_out_held", out_valid0, 1);
        end
        step();
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // clr after a partial block; clr wins over in_valid
    drive_taps(500, 1024, 5);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 12'sd999;
    in_coef = 12'sd1024;
    @(negedge clk);
    check_eq("clr_in_ready", in_ready0, 0);
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    model_clear();
    drive_taps(100, 1024, 8);
    wait_drain();

    // clr while a result is pending keeps that result
    out_ready = 1'b0;
    drive_taps(100, 1024, 8);
    drive_taps(500, 1024, 2);
    wait_out_valid("clr_pending_ready");
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("clr_pending_valid", out_valid0, 1);
    check_eq("clr_pending_data", out_data0, 400);
    step();
    out_ready = 1'b1;
    drive_taps(100, 1024, 8);
    wait_drain();

    // Asynchronous reset in the middle of tap 4
    drive_taps(-100, 1024, 3);
    in_valid = 1'b1;
    in_data = 12'sd100;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid0, 0);
    check_eq("midrst_out_data", out_data0, 0);
    check_eq("midrst_out_ovf", out_ovf0, 0);
    check_eq("midrst_in_ready", in_ready0, 0);
    model_clear();
    step();
    step();
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    step();

    // ena toggling every cycle: only enabled edges advance the pipeline
    ena_toggle = 1'b1;
    drive_taps(100, 1024, 8);
    en_edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid0) break;
      if (ena) en_edges++;
      step();
    end
    check_eq("ena_latency_edges", en_edges, 2);
    ena_toggle = 1'b0;
    ena = 1'b1;
    wait_drain();

    // Randomized blocks with random gaps and back-pressure
    rand_bp = 1'b1;
    for (int b = 0; b < 25; b++) begin
      for (int t = 0; t < TAPS; t++) begin
        repeat ($urandom_range(0, 2)) step();
        rd = 12'($urandom);
        rc = 12'($urandom);
        drive_tap(rd, rc);
      end
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    check_eq("final_queue_dut1", exp1.size(), 0);
    check_eq("final_queue_dut2", exp2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion",
             n_checks);
    $fatal(1, "watchdog");
  end

endmodule
